// File: rtl/cic_interp3_if.sv
// Sample bus of the CIC interpolator: strobe and sample in, ready, overrun
// pulse, output strobe and output sample out. dbg_state mirrors the control
// FSM state so checkers can bind to it.
//
// Handshake: a sample on Xin is taken on the rising clk edge where ND=1 and
// Rdy=1. ND=1 with Rdy=0 drops the sample and raises Ovr for one cycle after
// that edge. Vout=1 marks a cycle whose Yout was produced by the previous
// edge. Yout holds its value while Vout=0.
interface cic_interp3_if #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 17
) ();
  logic                    ND;
  logic signed [IN_W-1:0]  Xin;
  logic                    Rdy;
  logic                    Ovr;
  logic                    Vout;
  logic signed [OUT_W-1:0] Yout;
  logic [1:0]              dbg_state;

  modport master (output ND, output Xin,
                  input Rdy, input Ovr, input Vout, input Yout, input dbg_state);
  modport slave  (input ND, input Xin,
                  output Rdy, output Ovr, output Vout, output Yout, output dbg_state);
endinterface

// File: rtl/cic_interp3.sv
// Three-stage CIC interpolator, ratio R = 2^LOG2R.
// Combs run once per accepted sample, the comb output is zero-stuffed to the
// clk rate and integrated by three pipelined integrators. All internal math
// is IW-bit two's complement with wrap; integrator wrap is cancelled by the
// combs. Yout is I3 shifted right by 2*LOG2R (unity DC gain).
// Optional build macro CIC_ROUND_EN: round-half-up before the shift instead
// of truncation. No saturation in either build.
// Yout is sliced from IW bits, so OUT_W must not exceed IN_W + 3.
module cic_interp3 #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 17,
  parameter int LOG2R = 3
) (
  input  logic          clk,
  input  logic          rst,
  cic_interp3_if.slave  bus
);

  localparam int R  = 1 << LOG2R;
  localparam int SH = 2 * LOG2R;
  localparam int IW = IN_W + SH + 3;
  localparam logic [LOG2R-1:0] PH_LAST = LOG2R'(R - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LOG2R-1:0]  phase_q, phase_d;

  logic signed [IW-1:0] xin_ext;
  logic signed [IW-1:0] c1, c2, c3;
  logic signed [IW-1:0] d1_q, d2_q, d3_q;
  logic signed [IW-1:0] s_q, s_d;
  logic signed [IW-1:0] i1_q, i2_q, i3_q;
  logic [IW-1:0]        i3_r;
  logic signed [OUT_W-1:0] yout_q;
  logic                 vout_q;
  logic                 ovr_q;

  logic rdy;
  logic accept;
  logic active;
  logic unused_bits;

  // Comb chain is purely combinational from the delay registers.
  assign xin_ext = {{(IW-IN_W){bus.Xin[IN_W-1]}}, bus.Xin};
  assign c1      = xin_ext - d1_q;
  assign c2      = c1 - d2_q;
  assign c3      = c2 - d3_q;

  // Ready outside RUN, and in RUN only on the last phase of the window.
  assign rdy    = (state_q != ST_RUN) || (phase_q == PH_LAST);
  assign accept = bus.ND && rdy;
  assign active = (state_q == ST_RUN);

`ifdef CIC_ROUND_EN
  localparam logic [IW-1:0] RND = IW'(64'd1 << (SH - 1));
  assign i3_r = i3_q + RND;
`else
  assign i3_r = i3_q;
`endif

  assign unused_bits = ^{i3_r[IW-1:SH+OUT_W], i3_r[SH-1:0]};

  // Next-state logic: an accept opens a window of R active clocks.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE, ST_STALL: begin
        if (accept) begin
          state_d = ST_RUN;
          phase_d = '0;
        end
      end
      ST_RUN: begin
        if (phase_q == PH_LAST) begin
          if (accept) begin
            phase_d = '0;
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          phase_d = phase_q + LOG2R'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Stuff register: new comb sample on accept, zero after each active edge.
  always_comb begin
    s_d = s_q;
    if (accept) begin
      s_d = c3;
    end else if (active) begin
      s_d = '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Comb delays advance only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
      s_q  <= '0;
    end else begin
      s_q <= s_d;
      if (accept) begin
        d1_q <= xin_ext;
        d2_q <= c1;
        d3_q <= c2;
      end
    end
  end

  // Integrators and output register run on active edges only, each stage
  // taking the pre-edge value of the one before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_q   <= '0;
      i2_q   <= '0;
      i3_q   <= '0;
      yout_q <= '0;
      vout_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      vout_q <= active;
      ovr_q  <= bus.ND && !rdy;
      if (active) begin
        i1_q   <= i1_q + s_q;
        i2_q   <= i2_q + i1_q;
        i3_q   <= i3_q + i2_q;
        yout_q <= i3_r[SH+OUT_W-1:SH];
      end
    end
  end

  assign bus.Rdy       = rdy;
  assign bus.Ovr       = ovr_q;
  assign bus.Vout      = vout_q;
  assign bus.Yout      = yout_q;
  assign bus.dbg_state = state_q;

endmodule
